// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
// Provides the FSM state enum and a minimum-1 ceil-log2 helper.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // ceil(log2(n)) with a floor of 1 so a 1-entry counter still has a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder slice.
// Ports: x, y operands; ci carry-in; s sum; co carry-out.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder computing a+b+cin CHUNK bits per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a, b, cin
// operand handshake; out_valid/out_ready + sum, cout result handshake;
// busy while adding. Optional ovf output when SEQ_CHUNK_ADDER_OVF_EN
// is defined (signed overflow, registered with cout).
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SEQ_CHUNK_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = clog2_min1(NCHUNK);
    localparam int IW     = clog2_min1(WIDTH);

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK and >= CHUNK");
    end

    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [IW-1:0]     base;
    logic [CHUNK-1:0]  ch_s;
    logic              ch_co;

    // Bit offset of the chunk being added this cycle.
    assign base = IW'(cnt_q) * IW'(CHUNK);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x  (a_q[base +: CHUNK]),
        .y  (b_q[base +: CHUNK]),
        .ci (carry_q),
        .s  (ch_s),
        .co (ch_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: CHUNK] = ch_s;
                carry_d              = ch_co;
                if (cnt_q == LAST) begin
                    cout_d  = ch_co;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                    // ch_s MSB is the final sum MSB in the last chunk.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (ch_s[CHUNK-1] != a_q[WIDTH-1]);
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder.
// Covers a 16/4 instance and an 8/8 single-chunk instance.
module tb_seq_chunk_adder;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        busy8;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic        ovf;
    logic        ovf8;
`endif

    int ncmp;
    int nerr;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .busy      (busy8)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
       ,.ovf       (ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] va, input logic [15:0] vb,
                          input logic vc);
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        ncmp++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        ncmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_flags: got ov=%b busy=%b want 0/0",
                     out_valid, busy);
        end
        ncmp++;
        if (sum !== 16'h0000 || cout !== 1'b0) begin
            nerr++;
            $display("FAIL reset_sum: got %h/%b want 0000/0", sum, cout);
        end
        ncmp++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            nerr++;
            $display("FAIL reset_dut8: got ir=%b ov=%b want 1/0",
                     in_ready8, out_valid8);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        accept(16'h1234, 16'h4321, 1'b0);
        ncmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL basic_run: got busy=%b ir=%b want 1/0",
                     busy, in_ready);
        end
        tick();
        tick();
        tick();
        ncmp++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL basic_early: got ov=%b want 0", out_valid);
        end
        tick();
        ncmp++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL basic_latency: got ov=%b busy=%b want 1/0",
                     out_valid, busy);
        end
        ncmp++;
        if (sum !== 16'h5555 || cout !== 1'b0) begin
            nerr++;
            $display("FAIL basic_sum: got %h/%b want 5555/0", sum, cout);
        end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        ncmp++;
        if (ovf !== 1'b0) begin
            nerr++;
            $display("FAIL basic_ovf: got %b want 0", ovf);
        end
`endif
        release_result();
        ncmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL basic_release: got ov=%b ir=%b want 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_carry_ripple();
        accept(16'hFFFF, 16'h0000, 1'b1);
        repeat (4) tick();
        ncmp++;
        if (out_valid !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin
            nerr++;
            $display("FAIL ripple: got ov=%b %h/%b want 1 0000/1",
                     out_valid, sum, cout);
        end
        release_result();
    endtask

    task automatic test_all_ones();
        accept(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (4) tick();
        ncmp++;
        if (out_valid !== 1'b1 || sum !== 16'hFFFF || cout !== 1'b1) begin
            nerr++;
            $display("FAIL all_ones: got ov=%b %h/%b want 1 ffff/1",
                     out_valid, sum, cout);
        end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        ncmp++;
        if (ovf !== 1'b0) begin
            nerr++;
            $display("FAIL all_ones_ovf: got %b want 0", ovf);
        end
`endif
        release_result();
    endtask

    task automatic test_backpressure();
        accept(16'hABCD, 16'h1111, 1'b0);
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            a        = a ^ 16'h5A5A;
            b        = b + 16'h0101;
            in_valid = ~in_valid;
            ncmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                sum !== 16'hBCDE || cout !== 1'b0) begin
                nerr++;
                $display("FAIL backpressure[%0d]: got ov=%b ir=%b %h/%b want 1 0 bcde/0",
                         i, out_valid, in_ready, sum, cout);
            end
            tick();
        end
        in_valid = 1'b0;
        release_result();
        ncmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL backpressure_release: got ov=%b ir=%b want 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        accept(16'h1234, 16'h4321, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ncmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            busy !== 1'b0 || sum !== 16'h0000) begin
            nerr++;
            $display("FAIL reset_mid_run: got ov=%b ir=%b busy=%b sum=%h want 0 1 0 0000",
                     out_valid, in_ready, busy, sum);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        ncmp++;
        if (seen !== 1'b0) begin
            nerr++;
            $display("FAIL reset_discard: got result seen=%b want 0", seen);
        end
    endtask

    task automatic test_single_chunk();
        a8        = 8'h80;
        b8        = 8'h80;
        cin8      = 1'b0;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        ncmp++;
        if (out_valid8 !== 1'b1 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
            nerr++;
            $display("FAIL single_chunk: got ov=%b %h/%b want 1 00/1",
                     out_valid8, sum8, cout8);
        end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        ncmp++;
        if (ovf8 !== 1'b1) begin
            nerr++;
            $display("FAIL single_chunk_ovf: got %b want 1", ovf8);
        end
`endif
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        ncmp++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            nerr++;
            $display("FAIL single_chunk_release: got ov=%b ir=%b want 0/1",
                     out_valid8, in_ready8);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vc [3];
        logic [15:0] es [3];
        logic        ec [3];
        logic        eo [3];
        int          acc_cyc [3];
        int          nacc;
        int          nres;
        bit          acc;
        va[0] = 16'h0F0F; vb[0] = 16'h00F1; vc[0] = 1'b1;
        es[0] = 16'h1001; ec[0] = 1'b0;     eo[0] = 1'b0;
        va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b0;
        es[1] = 16'h0000; ec[1] = 1'b1;     eo[1] = 1'b1;
        va[2] = 16'h7FFF; vb[2] = 16'h0001; vc[2] = 1'b0;
        es[2] = 16'h8000; ec[2] = 1'b0;     eo[2] = 1'b1;
        nacc = 0;
        nres = 0;
        for (int i = 0; i < 3; i++) acc_cyc[i] = 0;
        out_ready = 1'b1;
        a         = va[0];
        b         = vb[0];
        cin       = vc[0];
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = in_valid && (in_ready === 1'b1);
            tick();
            if (acc && nacc < 3) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc < 3) begin
                    a   = va[nacc];
                    b   = vb[nacc];
                    cin = vc[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1 && nres < 3) begin
                ncmp++;
                if (sum !== es[nres] || cout !== ec[nres]) begin
                    nerr++;
                    $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b",
                             nres, sum, cout, es[nres], ec[nres]);
                end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                ncmp++;
                if (ovf !== eo[nres]) begin
                    nerr++;
                    $display("FAIL b2b_ovf[%0d]: got %b want %b",
                             nres, ovf, eo[nres]);
                end
`endif
                nres++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ncmp++;
        if (nacc !== 3 || nres !== 3) begin
            nerr++;
            $display("FAIL b2b_count: got acc=%0d res=%0d want 3/3",
                     nacc, nres);
        end
        ncmp++;
        if (acc_cyc[1] - acc_cyc[0] !== 6 ||
            acc_cyc[2] - acc_cyc[1] !== 6) begin
            nerr++;
            $display("FAIL b2b_interval: got %0d,%0d want 6,6",
                     acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
    endtask

    initial begin
        ncmp       = 0;
        nerr       = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        out_ready  = 1'b0;
        in_valid8  = 1'b0;
        a8         = '0;
        b8         = '0;
        cin8       = 1'b0;
        out_ready8 = 1'b0;
        test_reset();
        test_basic();
        test_carry_ripple();
        test_all_ones();
        test_backpressure();
        test_reset_mid_run();
        test_single_chunk();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder that computes WIDTH-bit A+B+cin, CHUNK bits per clock, through a registered carry chain.
- Successor to the fixed 4-bit serial/parallel adders: arbitrary width, a selectable chunk size, and valid/ready handshakes on input and output.
- Sits between operand registers or switch inputs and a result display or consumer.
- Trades latency (WIDTH/CHUNK cycles) for a short combinational path.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be ≥ CHUNK.
- CHUNK, 4, bits added per cycle. WIDTH % CHUNK must equal 0; otherwise elaboration fails via a generate-time error.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- cin  in  1  carry-in, active-high. Any push-button inversion happens at top level.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, registered.
- cout  out  1  carry-out of the MSB, registered.
- busy  out  1  high in RUN.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Internal chunk counter=0, carry register=0.
- Derived constant: NCHUNK = WIDTH/CHUNK. The counter width is clog2(NCHUNK), minimum 1.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b and cin (cin goes into the carry register), clear sum, set counter=0, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, add chunk k = counter: bits [k*CHUNK +: CHUNK] of A and B plus the carry register.
  - Write the CHUNK-bit result into sum[k*CHUNK +: CHUNK] and the chunk carry-out into the carry register.
  - If k == NCHUNK-1, go to DONE with cout = final carry. Otherwise counter increments.
- DONE:
  - out_valid=1. sum and cout are stable and held.
  - On out_ready: go to IDLE, out_valid=0.
- Latency:
  - Operand accept at edge E0 → out_valid high after edge E0+NCHUNK, i.e. NCHUNK cycles.
  - Minimum initiation interval is NCHUNK+2 cycles: in_ready rises the cycle after the result handshake, with no same-cycle re-accept.
- Boundaries:
  - Operands and in_valid are ignored outside IDLE; the latched copies are used.
  - out_ready is ignored outside DONE.
  - If out_ready is held high continuously, DONE lasts exactly 1 cycle.
  - NCHUNK==1 (WIDTH==CHUNK): RUN lasts 1 cycle, giving a single-cycle registered add.
  - All-ones + all-ones + cin=1: sum = all-ones, cout = 1, with the carry propagated across every chunk.
  - Reset mid-RUN or in DONE: abort the operation, all outputs go to reset values next edge, and the result is discarded.
  - rst has priority over every handshake in the same cycle.
- Arithmetic: unsigned, with no saturation. sum is the exact low WIDTH bits of a+b+cin, and cout is bit WIDTH.

Optional Feature:
- Macro: SEQ_CHUNK_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (out, 1): two's-complement signed overflow, equal to (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - ovf is registered together with cout in the last RUN cycle, valid while out_valid, and reset to 0.
- Undefined:
  - No ovf port and no related logic. Behaviour is otherwise identical.

Decomposition:
- Shared package seq_chunk_adder_pkg: state enum (IDLE, RUN, DONE) and the clog2 helper function.
- Sub-module chunk_adder: combinational CHUNK-bit ripple adder, with inputs x, y, ci and outputs s, co. Instantiate it once and reuse it every cycle.
- The FSM, counter and registers live in the top module.

Test Plan:
- WIDTH=16, CHUNK=4: a=16'h1234, b=16'h4321, cin=0 → after 4 cycles out_valid=1, sum=16'h5555, cout=0.
- WIDTH=16, CHUNK=4: a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1, full carry ripple through all chunks.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and toggle a/b/in_valid meanwhile → sum, cout and out_valid stay stable and in_ready stays 0. Raise out_ready → IDLE, then in_ready=1 the next cycle.
- Reset mid-RUN: assert rst in the 2nd RUN cycle → next edge out_valid=0, sum=0, in_ready=1, and no result emerges.
- WIDTH=8, CHUNK=8: a=8'h80, b=8'h80, cin=0 → out_valid 1 cycle after accept, sum=8'h00, cout=1. With SEQ_CHUNK_ADDER_OVF_EN defined, ovf=1.
- Back-to-back, with out_ready tied high and in_valid tied high: 3 operand sets are accepted at an interval of exactly NCHUNK+2 cycles, and each result matches the reference model.
